// File: rtl/ramb_load_accum_if.sv
// Bundle of the upstream byte handshake, control/result and RAM port signals
// between ramb_load_accum (master) and its environment (slave).
interface ramb_load_accum_if #(
    parameter int SUM_W = 16
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             start;
    logic             busy;
    logic [SUM_W-1:0] sum;
    logic             sum_valid;
    logic             ram_we;
    logic [5:0]       ram_a;
    logic [7:0]       ram_di;
    logic [7:0]       ram_do;

    modport master (
        input  in_valid, in_data, start, ram_do,
        output in_ready, busy, sum, sum_valid, ram_we, ram_a, ram_di
    );

    modport slave (
        output in_valid, in_data, start, ram_do,
        input  in_ready, busy, sum, sum_valid, ram_we, ram_a, ram_di
    );
endinterface

// File: rtl/ramb_load_accum.sv
// Loads a byte stream into a 64x8 single-port RAM, then reads it back and sums it.
// Optional macro RAMB_LOAD_ACCUM_CLR_EN adds a CLEAR pass that zeroes the used entries.
module ramb_load_accum #(
    parameter int DEPTH = 10,
    parameter int SUM_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    ramb_load_accum_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
`ifdef RAMB_LOAD_ACCUM_CLR_EN
        S_CLEAR = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_next;
    logic [CW-1:0]    r_wr_cnt, r_rd_cnt;
    logic [SUM_W-1:0] r_acc, w_acc_next, r_sum;
    logic             r_sum_valid;
    logic             w_in_ready, w_accept, w_last;
    logic [CW-1:0]    w_start_cnt;

    assign w_in_ready  = (r_state == S_IDLE) && (r_wr_cnt < CW'(DEPTH));
    assign w_accept    = bus.in_valid && w_in_ready;
    // A byte accepted in the start cycle is counted, so the stored count is wr_cnt+1.
    assign w_start_cnt = r_wr_cnt + CW'(w_accept);
    // r_wr_cnt holds the stored count N for the whole read/clear pass.
    assign w_last      = (r_rd_cnt + CW'(1)) == r_wr_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_sum_valid <= (w_state_next == S_DONE);
            if (w_state_next == S_DONE) r_sum <= w_acc_next;
            case (r_state)
                S_IDLE: begin
                    if (w_accept)  r_wr_cnt <= r_wr_cnt + CW'(1);
                    if (bus.start) r_rd_cnt <= '0;
                end
                S_READ:  r_rd_cnt <= w_last ? '0 : r_rd_cnt + CW'(1);
`ifdef RAMB_LOAD_ACCUM_CLR_EN
                S_CLEAR: r_rd_cnt <= r_rd_cnt + CW'(1);
`endif
                S_DONE:  r_wr_cnt <= '0;
                default: ;
            endcase
        end
    end

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_acc_next   = '0;
                    w_state_next = (w_start_cnt == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                w_acc_next = r_acc + SUM_W'(bus.ram_do);
`ifdef RAMB_LOAD_ACCUM_CLR_EN
                if (w_last) w_state_next = S_CLEAR;
`else
                if (w_last) w_state_next = S_DONE;
`endif
            end
`ifdef RAMB_LOAD_ACCUM_CLR_EN
            S_CLEAR: if (w_last) w_state_next = S_DONE;
`endif
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // RAM contents are never reset; clearing wr_cnt is what discards them.
    always_comb begin
        bus.in_ready  = w_in_ready;
        bus.busy      = (r_state != S_IDLE);
        bus.sum       = r_sum;
        bus.sum_valid = r_sum_valid;
        bus.ram_we    = 1'b0;
        bus.ram_a     = '0;
        bus.ram_di    = '0;
        case (r_state)
            S_IDLE: begin
                bus.ram_a = 6'(r_wr_cnt);
                if (w_accept) begin
                    bus.ram_we = 1'b1;
                    bus.ram_di = bus.in_data;
                end
            end
            S_READ:  bus.ram_a = 6'(r_rd_cnt);
`ifdef RAMB_LOAD_ACCUM_CLR_EN
            S_CLEAR: begin
                bus.ram_we = 1'b1;
                bus.ram_a  = 6'(r_rd_cnt);
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ramb_load_accum.sv
// Scoreboard bench for ramb_load_accum: stimulus pushes expected sums and arrival
// cycles; a negedge monitor pops them whenever sum_valid is seen.
module tb_ramb_load_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_writes = 0;
    logic [7:0] mem [64];

    typedef struct {
        logic [15:0] sum;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    ramb_load_accum_if #(.SUM_W(16)) bus ();

    ramb_load_accum #(.DEPTH(10), .SUM_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: synchronous write, combinational read.
    assign bus.ram_do = mem[bus.ram_a];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_a] <= bus.ram_di;
            n_writes       <= n_writes + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int lat(input int n);
`ifdef RAMB_LOAD_ACCUM_CLR_EN
        return 2 * n + 1;
`else
        return n + 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.sum_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sum_valid: got sum 0x%0h expected no strobe (cycle %0d)", bus.sum, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", int'(bus.sum), int'(e.sum));
                check("sum_valid_cycle", cyc, e.cyc);
            end
        end
    end

    // All drive helpers are entered and left at a negedge.
    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] s, input int n);
        exp_t e;
        e.sum = s;
        e.cyc = cyc + lat(n);
        exp_q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_done_in_time", int'(ok), 1);
        @(negedge clk);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.start    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_sum", int'(bus.sum), 0);
        check("rst_ram_we", int'(bus.ram_we), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full load 1..10 back-to-back; in_ready must drop after the 10th byte.
        for (int i = 1; i <= 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(i);
            #1;
            check("load_in_ready", int'(bus.in_ready), 1);
            check("load_ram_a", int'(bus.ram_a), i - 1);
            @(negedge clk);
        end
        bus.in_data = 8'd11;
        #1;
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_ram_we", int'(bus.ram_we), 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) check("mem_loaded", int'(mem[i]), i + 1);
        do_start(16'd55, 10);
        #1;
        check("busy_in_read", int'(bus.busy), 1);
        wait_done();
        check("sum_held", int'(bus.sum), 55);
        for (int i = 0; i < 10; i++) begin
`ifdef RAMB_LOAD_ACCUM_CLR_EN
            check("mem_after_clear", int'(mem[i]), 0);
`else
            check("mem_kept", int'(mem[i]), i + 1);
`endif
        end

        // Partial load with bubbles.
        send_byte(8'hFF);
        @(negedge clk);
        send_byte(8'h80);
        @(negedge clk);
        @(negedge clk);
        send_byte(8'h01);
        do_start(16'h0180, 3);
        wait_done();

        // Empty start: no writes, strobe next cycle.
        w0 = n_writes;
        do_start(16'h0000, 0);
        wait_done();
        check("empty_no_writes", n_writes, w0);

        // Nine 0x10 bytes, then a byte and start in the same cycle.
        for (int i = 0; i < 9; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'h10;
            @(negedge clk);
        end
        bus.in_data = 8'h20;
        #1;
        check("simul_ram_we", int'(bus.ram_we), 1);
        check("simul_ram_a", int'(bus.ram_a), 9);
        do_start(16'h00B0, 10);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        bus.start    = 1'b1;
        #1;
        check("read_in_ready", int'(bus.in_ready), 0);
        check("read_ram_we", int'(bus.ram_we), 0);
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        wait_done();
`ifdef RAMB_LOAD_ACCUM_CLR_EN
        check("mem9", int'(mem[9]), 0);
`else
        check("mem9", int'(mem[9]), 8'h20);
`endif
        check("mem10_untouched", int'(mem[10]), 0);

        // Reset mid-READ, then a clean 2-byte load.
        send_byte(8'd5);
        send_byte(8'd6);
        send_byte(8'd7);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_sum", int'(bus.sum), 0);
        check("midrst_sum_valid", int'(bus.sum_valid), 0);
        check("midrst_ram_a", int'(bus.ram_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h11);
        send_byte(8'h22);
        do_start(16'h0033, 2);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ramb_load_accum.md
# ramb_load_accum

Controller that sits directly upstream of the 64-address x 8-bit single-port RAM (synchronous write, combinational read) and owns all of its ports. It accepts a byte stream through a valid/ready handshake and writes it to consecutive addresses from 0. On `start`, it reads the stored bytes back one per cycle, sums them, and presents the sum with a one-cycle `sum_valid` strobe.

## Interface
- `DEPTH`, default 10: number of RAM entries used; legal range 1..64.
- `SUM_W`, default 16: accumulator and `sum` width; must hold DEPTH*255.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  controller can accept a byte this cycle.
- `start`  in  1  begin read-back/accumulate; sampled only in IDLE.
- `busy`  out  1  high in every state other than IDLE.
- `sum`  out  SUM_W  last completed sum; held until the next DONE.
- `sum_valid`  out  1  one-cycle strobe, high only in DONE.
- `ram_we`  out  1  RAM write enable.
- `ram_a`  out  6  RAM address.
- `ram_di`  out  8  RAM write data.
- `ram_do`  in  8  RAM read data, combinational from `ram_a`.

## Operation
- State register: IDLE, READ, CLEAR (only with the macro), DONE. Counters: `wr_cnt`, `rd_cnt`, each 0..DEPTH. Accumulator: `acc`, SUM_W bits.
- Reset values: state=IDLE, wr_cnt=0, rd_cnt=0, acc=0, sum=0, sum_valid=0, in_ready=1, busy=0, ram_we=0, ram_a=0, ram_di=0.
- **IDLE**
  - `in_ready` = (wr_cnt < DEPTH).
  - On `in_valid & in_ready`: ram_we=1, ram_a=wr_cnt, ram_di=in_data, and wr_cnt increments.
  - When wr_cnt = DEPTH, `in_ready` is 0 and writes stop; nothing wraps or overwrites.
  - On `start`: rd_cnt←0, acc←0, go to READ. If the same cycle also holds an accepted byte, the write completes and that byte is included (count = wr_cnt+1).
- **READ**
  - ram_a=rd_cnt, ram_we=0, in_ready=0.
  - Each cycle: acc←acc+ram_do (ram_do zero-extended), rd_cnt increments.
  - After rd_cnt reaches the stored count, go to DONE, or to CLEAR when the macro is defined.
  - Addition is modulo 2^SUM_W; with legal parameters it never overflows.
- **start with count 0**: go directly to DONE with acc=0. READ is not entered.
- **DONE**: sum←acc, sum_valid=1 for exactly one cycle, wr_cnt←0, go to IDLE. The next load overwrites from address 0.
- `start` outside IDLE is ignored. `in_valid` outside IDLE is not accepted (in_ready=0).
- Reset mid-operation clears all state immediately. RAM contents are not touched, but they are logically discarded (wr_cnt=0).
- When ram_we=0, ram_di=0 and ram_a follows the table above (wr_cnt in IDLE, rd_cnt in READ/CLEAR, 0 in DONE).

## Timing
- Write latency: a byte accepted at edge k is in the RAM after edge k.
- Read-back: count N≥1 and `start` sampled at edge 0.
  - READ occupies cycles 1..N.
  - `sum_valid` is high during cycle N+1.
  - `sum` is valid from cycle N+1 until the next DONE.
- With CLEAR: `sum_valid` is high during cycle 2N+1.
- N=0: `sum_valid` is high during cycle 1.
- in_ready and ram_we/ram_a/ram_di are combinational from state, counters and in_valid. sum and sum_valid are registered.

## Configuration
- `RAMB_LOAD_ACCUM_CLR_EN` defined:
  - After READ, enter CLEAR for N cycles: ram_we=1, ram_a=0..N-1, ram_di=0.
  - Then go to DONE.
  - Used entries read 0 afterwards.
- Undefined: there is no CLEAR state, READ goes straight to DONE, and RAM contents are left intact.

## Test plan
- Reset behaviour: assert rst mid-READ -> all outputs return to reset values within the same cycle. A following 2-byte load plus start gives sum equal to those 2 bytes only.
- Full load: write 1,2,...,10 back-to-back -> in_ready drops after the 10th byte. start -> sum=55, sum_valid high exactly 11 cycles after start (21 with CLR_EN).
- Partial load with bubbles: toggle in_valid to load 0xFF,0x80,0x01 -> sum=0x0180, sum_valid 4 cycles after start.
- Empty start: start with wr_cnt=0 -> sum=0, sum_valid high in the next cycle, no RAM writes.
- Simultaneous events: with 9 bytes of 0x10 stored, drive in_valid=1, in_data=0x20 and start in the same cycle -> byte written to address 9, sum=0xB0. Extra bytes offered during READ are not accepted. Second start during READ is ignored.
- CLR_EN: after sum of 1..10, read the RAM model addresses 0..9 -> all 0. Without the macro -> still 1..10.
